// File: rtl/pipe_control_unit_if.sv
// Control-unit bus: ID-stage inputs (opcode, valid, hazard controls) and staged control outputs.
// Latency and backpressure are owned by pipe_control_unit; this only groups the wires.
interface pipe_control_unit_if #(
   parameter int unsigned ALUOP_W = 2,
   parameter int unsigned CNT_W   = 16
);
   logic [5:0]         opcode;
   logic               id_valid;
   logic               stall;
   logic               flush;
   logic               cnt_clr;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               ex_alu_src;
   logic               ex_reg_dst;
   logic               ex_illegal;
   logic               mem_branch;
   logic               mem_branch_ne;
   logic               mem_jump;
   logic               mem_read;
   logic               mem_write;
   logic               wb_reg_write;
   logic               wb_mem_to_reg;
   logic [CNT_W-1:0]   bubble_cnt;

   modport master (
      output opcode, id_valid, stall, flush, cnt_clr,
      input  ex_alu_op, ex_alu_src, ex_reg_dst, ex_illegal,
      input  mem_branch, mem_branch_ne, mem_jump, mem_read, mem_write,
      input  wb_reg_write, wb_mem_to_reg, bubble_cnt
   );

   modport slave (
      input  opcode, id_valid, stall, flush, cnt_clr,
      output ex_alu_op, ex_alu_src, ex_reg_dst, ex_illegal,
      output mem_branch, mem_branch_ne, mem_jump, mem_read, mem_write,
      output wb_reg_write, wb_mem_to_reg, bubble_cnt
   );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS main control: decodes ID opcode, stages it through ID/EX, EX/MEM, MEM/WB.
// ex_* one edge after accept, mem_* two, wb_* three; stall bubbles ID/EX, flush squashes ID and EX.
module pipe_control_unit #(
   parameter int unsigned ALUOP_W = 2,
   parameter int unsigned EN_ADDI = 1,
   parameter int unsigned EN_JUMP = 1,
   parameter int unsigned EN_BNE  = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipe_control_unit_if.slave   bus
);

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               reg_dst;
      logic               illegal;
      logic               branch;
      logic               branch_ne;
      logic               jump;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
   } id_ctrl_t;

   typedef struct packed {
      logic branch;
      logic branch_ne;
      logic jump;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   id_ctrl_t         dec;
   id_ctrl_t         idex_d,  idex_q;
   mem_ctrl_t        exmem_d, exmem_q;
   wb_ctrl_t         memwb_d, memwb_q;
   logic [CNT_W-1:0] cnt_d,   cnt_q;

   always_comb begin
      dec = '0;
      case (bus.opcode)
         6'b100011: begin
            dec.alu_src    = 1'b1;
            dec.mem_read   = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
         end
         6'b101011: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         6'b000100: begin
            dec.alu_op = ALUOP_W'(2'b01);
            dec.branch = 1'b1;
         end
         6'b000101: begin
            if (EN_BNE != 0) begin
               dec.alu_op    = ALUOP_W'(2'b01);
               dec.branch    = 1'b1;
               dec.branch_ne = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         6'b000000: begin
            dec.alu_op    = ALUOP_W'(2'b10);
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
         end
         6'b001000: begin
            if (EN_ADDI != 0) begin
               dec.alu_src   = 1'b1;
               dec.reg_write = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         6'b000010: begin
            if (EN_JUMP != 0) dec.jump    = 1'b1;
            else              dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // flush outranks stall; MEM/WB ignores flush so the resolving branch still retires
   always_comb begin
      idex_d  = (bus.flush || bus.stall || !bus.id_valid) ? '0 : dec;
      exmem_d = '0;
      if (!bus.flush) begin
         exmem_d.branch     = idex_q.branch;
         exmem_d.branch_ne  = idex_q.branch_ne;
         exmem_d.jump       = idex_q.jump;
         exmem_d.mem_read   = idex_q.mem_read;
         exmem_d.mem_write  = idex_q.mem_write;
         exmem_d.reg_write  = idex_q.reg_write;
         exmem_d.mem_to_reg = idex_q.mem_to_reg;
      end
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      cnt_d = cnt_q;
      if (bus.cnt_clr)
         cnt_d = '0;
      else if (bus.stall && !bus.flush && bus.id_valid && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
         cnt_q   <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ex_alu_op     = idex_q.alu_op;
   assign bus.ex_alu_src    = idex_q.alu_src;
   assign bus.ex_reg_dst    = idex_q.reg_dst;
   assign bus.ex_illegal    = idex_q.illegal;
   assign bus.mem_branch    = exmem_q.branch;
   assign bus.mem_branch_ne = exmem_q.branch_ne;
   assign bus.mem_jump      = exmem_q.jump;
   assign bus.mem_read      = exmem_q.mem_read;
   assign bus.mem_write     = exmem_q.mem_write;
   assign bus.wb_reg_write  = memwb_q.reg_write;
   assign bus.wb_mem_to_reg = memwb_q.mem_to_reg;
   assign bus.bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench: three control units (default, BNE disabled, 2-bit counter) share one stimulus
// stream and are compared each cycle against an instruction-slot reference model.
module tb_pipe_control_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [5:0] opcode;
   logic       id_valid, stall, flush, cnt_clr;

   pipe_control_unit_if #(.ALUOP_W(2), .CNT_W(16)) bus_m  ();
   pipe_control_unit_if #(.ALUOP_W(2), .CNT_W(16)) bus_nb ();
   pipe_control_unit_if #(.ALUOP_W(2), .CNT_W(2))  bus_c2 ();

   assign bus_m.opcode   = opcode;   assign bus_m.id_valid  = id_valid;
   assign bus_m.stall    = stall;    assign bus_m.flush     = flush;
   assign bus_m.cnt_clr  = cnt_clr;
   assign bus_nb.opcode  = opcode;   assign bus_nb.id_valid = id_valid;
   assign bus_nb.stall   = stall;    assign bus_nb.flush    = flush;
   assign bus_nb.cnt_clr = cnt_clr;
   assign bus_c2.opcode  = opcode;   assign bus_c2.id_valid = id_valid;
   assign bus_c2.stall   = stall;    assign bus_c2.flush    = flush;
   assign bus_c2.cnt_clr = cnt_clr;

   pipe_control_unit dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
   pipe_control_unit #(.EN_BNE(0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));
   pipe_control_unit #(.CNT_W(2))  dut_c2 (.clk(clk), .rst_n(rst_n), .bus(bus_c2));

   int checks = 0;
   int passes = 0;

   // Reference model: which instruction (opcode) sits in EX, MEM, WB; counters as plain integers
   logic [5:0] s_op [3];
   bit         s_v  [3];
   int         cnt_m, cnt_c;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                          OP_BNE = 6'b000101, OP_R = 6'b000000, OP_ADDI = 6'b001000,
                          OP_J = 6'b000010, OP_BAD = 6'b111111;

   // {alu_op[1:0], alu_src, reg_dst, illegal, branch, branch_ne, jump, mem_read, mem_write, reg_write, mem_to_reg}
   function automatic logic [11:0] dec(input logic [5:0] op, input bit en_bne);
      case (op)
         OP_LW:   return 12'b00_1_0_0_0_0_0_1_0_1_1;
         OP_SW:   return 12'b00_1_0_0_0_0_0_0_1_0_0;
         OP_BEQ:  return 12'b01_0_0_0_1_0_0_0_0_0_0;
         OP_BNE:  return en_bne ? 12'b01_0_0_0_1_1_0_0_0_0_0 : 12'b00_0_0_1_0_0_0_0_0_0_0;
         OP_R:    return 12'b10_0_1_0_0_0_0_0_0_1_0;
         OP_ADDI: return 12'b00_1_0_0_0_0_0_0_0_1_0;
         OP_J:    return 12'b00_0_0_0_0_0_1_0_0_0_0;
         default: return 12'b00_0_0_1_0_0_0_0_0_0_0;
      endcase
   endfunction

   function automatic logic [11:0] exp_vec(input bit en_bne);
      logic [11:0] e, m, w;
      e = s_v[0] ? dec(s_op[0], en_bne) : 12'h0;
      m = s_v[1] ? dec(s_op[1], en_bne) : 12'h0;
      w = s_v[2] ? dec(s_op[2], en_bne) : 12'h0;
      return {e[11:7], m[6:2], w[1:0]};
   endfunction

   function automatic logic [53:0] exp_all();
      logic [15:0] cm;
      logic [1:0]  cc;
      cm = 16'(cnt_m);
      cc = 2'(cnt_c);
      return {exp_vec(1'b1), exp_vec(1'b0), exp_vec(1'b1), cm, cc};
   endfunction

   function automatic logic [53:0] obs_all();
      return {bus_m.ex_alu_op, bus_m.ex_alu_src, bus_m.ex_reg_dst, bus_m.ex_illegal,
              bus_m.mem_branch, bus_m.mem_branch_ne, bus_m.mem_jump, bus_m.mem_read,
              bus_m.mem_write, bus_m.wb_reg_write, bus_m.wb_mem_to_reg,
              bus_nb.ex_alu_op, bus_nb.ex_alu_src, bus_nb.ex_reg_dst, bus_nb.ex_illegal,
              bus_nb.mem_branch, bus_nb.mem_branch_ne, bus_nb.mem_jump, bus_nb.mem_read,
              bus_nb.mem_write, bus_nb.wb_reg_write, bus_nb.wb_mem_to_reg,
              bus_c2.ex_alu_op, bus_c2.ex_alu_src, bus_c2.ex_reg_dst, bus_c2.ex_illegal,
              bus_c2.mem_branch, bus_c2.mem_branch_ne, bus_c2.mem_jump, bus_c2.mem_read,
              bus_c2.mem_write, bus_c2.wb_reg_write, bus_c2.wb_mem_to_reg,
              bus_m.bubble_cnt, bus_c2.bubble_cnt};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 3; i++) begin
         s_v[i]  = 1'b0;
         s_op[i] = 6'h0;
      end
      cnt_m = 0;
      cnt_c = 0;
   endfunction

   function automatic void model_edge();
      if (!rst_n) begin
         model_clear();
         return;
      end
      s_op[2] = s_op[1]; s_v[2] = s_v[1];
      if (flush) s_v[1] = 1'b0;
      else begin s_op[1] = s_op[0]; s_v[1] = s_v[0]; end
      if (flush || stall || !id_valid) s_v[0] = 1'b0;
      else begin s_op[0] = opcode; s_v[0] = 1'b1; end
      if (cnt_clr) begin
         cnt_m = 0;
         cnt_c = 0;
      end else if (stall && !flush && id_valid) begin
         if (cnt_m < 65535) cnt_m++;
         if (cnt_c < 3)     cnt_c++;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic v, input logic st, input logic fl, input logic clr);
      opcode = op; id_valid = v; stall = st; flush = fl; cnt_clr = clr;
   endtask

   task automatic test_reset();
      drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0);
      model_clear();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs_all() !== 54'h0) $display("FAIL reset_hold[%0d] got=%h want=0", i, obs_all());
         else passes++;
         step();
      end
      #4 rst_n = 1'b1;
      drive(OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (obs_all() !== exp_all()) $display("FAIL reset_release got=%h want=%h", obs_all(), exp_all());
      else passes++;
   endtask

   task automatic test_reset_midstream();
      logic [5:0] seq [3];
      seq[0] = OP_LW; seq[1] = OP_R; seq[2] = OP_SW;
      for (int i = 0; i < 3; i++) begin
         drive(seq[i], 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         checks++;
         if (obs_all() !== exp_all()) $display("FAIL midstream_fill[%0d] got=%h want=%h", i, obs_all(), exp_all());
         else passes++;
      end
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (obs_all() !== 54'h0) $display("FAIL midstream_async_reset got=%h want=0", obs_all());
      else passes++;
      step();
      #3 rst_n = 1'b1;
      drive(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs_all() !== 54'h0) $display("FAIL midstream_empty[%0d] got=%h want=0", i, obs_all());
         else passes++;
      end
   endtask

   task automatic test_latency();
      drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      drive(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (!(bus_m.ex_alu_src === 1'b1 && bus_m.mem_read === 1'b0 && bus_m.wb_reg_write === 1'b0))
         $display("FAIL latency_ex src=%b rd=%b rw=%b want 1 0 0", bus_m.ex_alu_src, bus_m.mem_read, bus_m.wb_reg_write);
      else passes++;
      step();
      checks++;
      if (!(bus_m.ex_alu_src === 1'b0 && bus_m.mem_read === 1'b1 && bus_m.wb_reg_write === 1'b0))
         $display("FAIL latency_mem src=%b rd=%b rw=%b want 0 1 0", bus_m.ex_alu_src, bus_m.mem_read, bus_m.wb_reg_write);
      else passes++;
      step();
      checks++;
      if (!(bus_m.mem_read === 1'b0 && bus_m.wb_reg_write === 1'b1 && bus_m.wb_mem_to_reg === 1'b1))
         $display("FAIL latency_wb rd=%b rw=%b m2r=%b want 0 1 1", bus_m.mem_read, bus_m.wb_reg_write, bus_m.wb_mem_to_reg);
      else passes++;
      step();
      checks++;
      if (obs_all() !== exp_all()) $display("FAIL latency_drain got=%h want=%h", obs_all(), exp_all());
      else passes++;
   endtask

   task automatic test_load_use();
      drive(OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_R,  1'b1, 1'b1, 1'b0, 1'b0); step();
      checks++;
      if (!(bus_m.ex_alu_op === 2'b00 && bus_m.ex_reg_dst === 1'b0 && bus_m.mem_read === 1'b1))
         $display("FAIL load_use_bubble_ex op=%b dst=%b rd=%b want 00 0 1", bus_m.ex_alu_op, bus_m.ex_reg_dst, bus_m.mem_read);
      else passes++;
      drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         drive(OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs_all() !== exp_all()) $display("FAIL load_use[%0d] got=%h want=%h", i, obs_all(), exp_all());
         else passes++;
      end
      checks++;
      if (bus_m.bubble_cnt !== 16'd1) $display("FAIL load_use_cnt got=%0d want=1", bus_m.bubble_cnt);
      else passes++;
   endtask

   task automatic test_flush();
      drive(OP_BEQ, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_SW,  1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_ADDI, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (!(bus_m.mem_branch === 1'b1 && bus_m.ex_alu_src === 1'b1))
         $display("FAIL flush_setup br=%b src=%b want 1 1", bus_m.mem_branch, bus_m.ex_alu_src);
      else passes++;
      step();
      drive(OP_ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (!(bus_m.mem_write === 1'b0 && bus_m.ex_alu_src === 1'b0 && bus_m.wb_reg_write === 1'b0 &&
            bus_m.wb_mem_to_reg === 1'b0 && bus_m.mem_branch === 1'b0))
         $display("FAIL flush_squash wr=%b src=%b rw=%b m2r=%b br=%b want all 0", bus_m.mem_write,
                  bus_m.ex_alu_src, bus_m.wb_reg_write, bus_m.wb_mem_to_reg, bus_m.mem_branch);
      else passes++;
      checks++;
      if (obs_all() !== exp_all()) $display("FAIL flush_model got=%h want=%h", obs_all(), exp_all());
      else passes++;
      // resolving LW in MEM must still reach WB through a flush
      drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_R,  1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_SW, 1'b1, 1'b0, 1'b1, 1'b0); step();
      checks++;
      if (!(bus_m.wb_mem_to_reg === 1'b1 && bus_m.mem_read === 1'b0 && bus_m.ex_alu_src === 1'b0))
         $display("FAIL flush_retire m2r=%b rd=%b src=%b want 1 0 0", bus_m.wb_mem_to_reg, bus_m.mem_read, bus_m.ex_alu_src);
      else passes++;
   endtask

   task automatic test_params();
      drive(OP_BNE, 1'b1, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if (!(bus_nb.ex_illegal === 1'b1 && bus_nb.ex_alu_op === 2'b00 && bus_m.ex_illegal === 1'b0 &&
            bus_m.ex_alu_op === 2'b01))
         $display("FAIL params_bne nb_ill=%b nb_op=%b m_ill=%b m_op=%b want 1 00 0 01",
                  bus_nb.ex_illegal, bus_nb.ex_alu_op, bus_m.ex_illegal, bus_m.ex_alu_op);
      else passes++;
      drive(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if (!(bus_m.ex_illegal === 1'b1 && bus_m.ex_alu_src === 1'b0 && bus_m.ex_reg_dst === 1'b0 &&
            bus_nb.mem_branch === 1'b0 && bus_m.mem_branch_ne === 1'b1))
         $display("FAIL params_bad ill=%b src=%b dst=%b nb_br=%b m_bne=%b want 1 0 0 0 1", bus_m.ex_illegal,
                  bus_m.ex_alu_src, bus_m.ex_reg_dst, bus_nb.mem_branch, bus_m.mem_branch_ne);
      else passes++;
      drive(OP_J, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(OP_J, 1'b0, 1'b0, 1'b0, 1'b0); step();
      checks++;
      if (obs_all() !== exp_all()) $display("FAIL params_jump got=%h want=%h", obs_all(), exp_all());
      else passes++;
   endtask

   task automatic test_counter();
      drive(OP_R, 1'b0, 1'b0, 1'b0, 1'b1); step();
      drive(OP_R, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (!(bus_c2.bubble_cnt === 2'd3 && bus_m.bubble_cnt === 16'd5))
         $display("FAIL counter_sat c2=%0d m=%0d want 3 5", bus_c2.bubble_cnt, bus_m.bubble_cnt);
      else passes++;
      drive(OP_R, 1'b1, 1'b1, 1'b1, 1'b0); step();
      checks++;
      if (bus_m.bubble_cnt !== 16'd5) $display("FAIL counter_flush_nocount got=%0d want=5", bus_m.bubble_cnt);
      else passes++;
      drive(OP_R, 1'b1, 1'b1, 1'b0, 1'b1); step();
      checks++;
      if (!(bus_c2.bubble_cnt === 2'd0 && bus_m.bubble_cnt === 16'd0))
         $display("FAIL counter_clr c2=%0d m=%0d want 0 0", bus_c2.bubble_cnt, bus_m.bubble_cnt);
      else passes++;
      drive(OP_R, 1'b0, 1'b1, 1'b0, 1'b0); step();
      checks++;
      if (bus_m.bubble_cnt !== 16'd0) $display("FAIL counter_invalid_nocount got=%0d want=0", bus_m.bubble_cnt);
      else passes++;
   endtask

   task automatic test_random();
      logic [5:0] pool [8];
      int bad = 0;
      pool[0] = OP_LW; pool[1] = OP_SW; pool[2] = OP_BEQ; pool[3] = OP_BNE;
      pool[4] = OP_R;  pool[5] = OP_ADDI; pool[6] = OP_J; pool[7] = OP_BAD;
      for (int i = 0; i < 400; i++) begin
         opcode   = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 6'($urandom);
         id_valid = ($urandom_range(0, 9) < 8);
         stall    = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         cnt_clr  = ($urandom_range(0, 29) == 0);
         step();
         checks++;
         if (obs_all() !== exp_all()) begin
            if (bad < 5) $display("FAIL random[%0d] got=%h want=%h", i, obs_all(), exp_all());
            bad++;
         end else passes++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(6'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      test_reset();
      test_reset_midstream();
      test_latency();
      test_load_use();
      test_flush();
      test_params();
      test_counter();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
